// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared encodings for the I/O window sequencer
package io_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } io_state_e;

   localparam int DEV_SWITCH = 0;
   localparam int DEV_LED    = 1;
   localparam int DEV_SEG7   = 2;
   localparam int DEV_UART   = 3;

   localparam logic [21:0] IO_WINDOW_HI = 22'h3FFFFF;

   localparam int SLOT_W  = 3;
   localparam int TIMER_W = 8;

endpackage

// File: rtl/io_bus_ctrl_if.sv
// rtl/io_bus_ctrl_if.sv - CPU-side strobes and peripheral select/ack bus
interface io_bus_ctrl_if #(
   parameter int NUM_DEV = 4
);
   logic                   IORead;
   logic                   IOWrite;
   logic [9:0]             addr_low;
   logic [31:0]            wdata;
   logic                   stall;
   logic [31:0]            rdata;
   logic                   rdata_valid;
   logic                   io_err;
   logic [NUM_DEV-1:0]     dev_sel;
   logic                   dev_we;
   logic [3:0]             dev_addr;
   logic [31:0]            dev_wdata;
   logic [32*NUM_DEV-1:0]  dev_rdata;
   logic [NUM_DEV-1:0]     dev_ack;

   modport master (
      input  IORead, IOWrite, addr_low, wdata, dev_rdata, dev_ack,
      output stall, rdata, rdata_valid, io_err, dev_sel, dev_we, dev_addr, dev_wdata
   );

   modport slave (
      output IORead, IOWrite, addr_low, wdata, dev_rdata, dev_ack,
      input  stall, rdata, rdata_valid, io_err, dev_sel, dev_we, dev_addr, dev_wdata
   );

endinterface

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - maps addr_low to a 16-byte peripheral slot
module io_addr_decode
   import io_bus_pkg::*;
#(
   parameter int         NUM_DEV  = 4,
   parameter logic [9:0] BASE_OFF = 10'h060
) (
   input  logic [9:0]         addr_low,
   output logic               hit,
   output logic [SLOT_W-1:0]  slot,
   output logic [NUM_DEV-1:0] onehot
);

   logic [5:0] idx;

   // Subtraction wraps below BASE_OFF, so the >= test must gate the index compare.
   always_comb begin
      idx = 6'((addr_low - BASE_OFF) >> 4);
      hit = (addr_low >= BASE_OFF) && (idx < 6'(NUM_DEV));
      slot = idx[SLOT_W-1:0];
      onehot = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         onehot[i] = hit && (slot == SLOT_W'(i));
      end
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - multi-cycle select/ack sequencer for the I/O window
module io_bus_ctrl
   import io_bus_pkg::*;
#(
   parameter int         NUM_DEV  = 4,
   parameter logic [9:0] BASE_OFF = 10'h060,
   parameter int         TIMEOUT  = 15
) (
   input  logic          clock,
   input  logic          reset,
   io_bus_ctrl_if.master bus
);

   io_state_e            state_q, state_d;
   logic [NUM_DEV-1:0]   dev_sel_q, dev_sel_d;
   logic                 dev_we_q, dev_we_d;
   logic [3:0]           dev_addr_q, dev_addr_d;
   logic [31:0]          dev_wdata_q, dev_wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 rdata_valid_q, rdata_valid_d;
   logic                 io_err_q, io_err_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;

   logic                 dec_hit;
   logic [SLOT_W-1:0]    dec_slot;
   logic [NUM_DEV-1:0]   dec_onehot;
   logic                 req;
   logic                 ack_sel;
   logic [31:0]          rdata_sel;
   logic                 stall;

   io_addr_decode #(
      .NUM_DEV  (NUM_DEV),
      .BASE_OFF (BASE_OFF)
   ) u_decode (
      .addr_low (bus.addr_low),
      .hit      (dec_hit),
      .slot     (dec_slot),
      .onehot   (dec_onehot)
   );

   // dev_sel_q is one-hot on the active slot, so masking filters stray acks.
   always_comb begin
      ack_sel = |(bus.dev_ack & dev_sel_q);
      rdata_sel = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (slot_q == SLOT_W'(i)) begin
            rdata_sel = bus.dev_rdata[32*i +: 32];
         end
      end
   end

   always_comb begin
      req           = bus.IORead | bus.IOWrite;
      state_d       = state_q;
      dev_sel_d     = dev_sel_q;
      dev_we_d      = dev_we_q;
      dev_addr_d    = dev_addr_q;
      dev_wdata_d   = dev_wdata_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      io_err_d      = 1'b0;
      timer_d       = timer_q;
      slot_d        = slot_q;
      stall         = 1'b0;

      unique case (state_q)
         IDLE: begin
            stall = req;
            if (req) begin
               dev_we_d    = bus.IOWrite;
               dev_addr_d  = bus.addr_low[3:0];
               dev_wdata_d = bus.wdata;
               if (dec_hit && (bus.IORead ^ bus.IOWrite)) begin
                  state_d   = ACCESS;
                  dev_sel_d = dec_onehot;
                  slot_d    = dec_slot;
                  timer_d   = '0;
               end else begin
                  state_d  = DONE;
                  io_err_d = 1'b1;
                  rdata_d  = '0;
               end
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (ack_sel) begin
               state_d   = DONE;
               dev_sel_d = '0;
               if (!dev_we_q) begin
                  rdata_d       = rdata_sel;
                  rdata_valid_d = 1'b1;
               end
            end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
               state_d   = DONE;
               dev_sel_d = '0;
               io_err_d  = 1'b1;
               rdata_d   = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         dev_sel_q     <= '0;
         dev_we_q      <= 1'b0;
         dev_addr_q    <= '0;
         dev_wdata_q   <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         io_err_q      <= 1'b0;
         timer_q       <= '0;
         slot_q        <= '0;
      end else begin
         state_q       <= state_d;
         dev_sel_q     <= dev_sel_d;
         dev_we_q      <= dev_we_d;
         dev_addr_q    <= dev_addr_d;
         dev_wdata_q   <= dev_wdata_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         io_err_q      <= io_err_d;
         timer_q       <= timer_d;
         slot_q        <= slot_d;
      end
   end

   assign bus.stall       = stall;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.io_err      = io_err_q;
   assign bus.dev_sel     = dev_sel_q;
   assign bus.dev_we      = dev_we_q;
   assign bus.dev_addr    = dev_addr_q;
   assign bus.dev_wdata   = dev_wdata_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - directed and randomized bench for io_bus_ctrl
module tb_io_bus_ctrl;

   localparam int NUM_DEV = 4;
   localparam int TIMEOUT = 15;
   localparam int BASE    = 96;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] rv [NUM_DEV];
   logic [31:0] rdata_hold = 32'h0;

   io_bus_ctrl_if #(.NUM_DEV(NUM_DEV)) bus ();

   io_bus_ctrl #(
      .NUM_DEV  (NUM_DEV),
      .BASE_OFF (10'h060),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel"},   32'(bus.dev_sel), 32'h0);
      chk({tag, "_we"},    32'(bus.dev_we), 32'h0);
      chk({tag, "_addr"},  32'(bus.dev_addr), 32'h0);
      chk({tag, "_wdata"}, bus.dev_wdata, 32'h0);
      chk({tag, "_rdata"}, bus.rdata, 32'h0);
      chk({tag, "_valid"}, 32'(bus.rdata_valid), 32'h0);
      chk({tag, "_err"},   32'(bus.io_err), 32'h0);
      chk({tag, "_stall"}, 32'(bus.stall), 32'h0);
   endtask

   // One CPU I/O instruction; ack_dly = ACCESS cycle (0-based) in which the slot acks.
   task automatic run_access(input logic rd, input logic wr, input logic [9:0] a,
                             input logic [31:0] wd, input int ack_dly,
                             input logic [NUM_DEV-1:0] stray);
      int                 ai;
      int                 slot;
      bit                 hit, go, acked, exp_err, exp_valid;
      int                 exp_stall;
      logic [NUM_DEV-1:0] exp_sel;
      logic [31:0]        exp_rdata;
      int                 n_stall;
      int                 k;
      bit                 done;

      ai        = int'(a);
      hit       = (ai >= BASE) && ((ai - BASE) / 16 < NUM_DEV);
      slot      = hit ? (ai - BASE) / 16 : 0;
      go        = hit && (rd != wr);
      exp_sel   = '0;
      if (go) exp_sel[slot] = 1'b1;
      acked     = go && (ack_dly < TIMEOUT);
      exp_stall = go ? (acked ? ack_dly + 2 : TIMEOUT + 1) : 1;
      exp_err   = !acked;
      exp_valid = acked && rd;
      exp_rdata = exp_err ? 32'h0 : (exp_valid ? rv[slot] : rdata_hold);

      for (int i = 0; i < NUM_DEV; i++) bus.dev_rdata[32*i +: 32] = rv[i];
      @(negedge clk);
      bus.IORead   = rd;
      bus.IOWrite  = wr;
      bus.addr_low = a;
      bus.wdata    = wd;
      bus.dev_ack  = '0;
      #1 chk("stall_req", 32'(bus.stall), 32'h1);

      n_stall = 1;
      k = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         if (bus.stall !== 1'b1) begin
            done = 1;
         end else begin
            n_stall++;
            if (k == 0) begin
               chk("dev_we",    32'(bus.dev_we), 32'(wr));
               chk("dev_addr",  32'(bus.dev_addr), 32'(a[3:0]));
               chk("dev_wdata", bus.dev_wdata, wd);
            end
            chk("dev_sel_hold", 32'(bus.dev_sel), 32'(exp_sel));
            bus.dev_ack = (stray & ~exp_sel) | ((k == ack_dly) ? exp_sel : '0);
            k++;
            if (k > 4 * TIMEOUT) begin
               checks++;
               failures++;
               $error("FAIL wait_bound observed=%0d expected<=%0d", k, TIMEOUT);
               done = 1;
            end
         end
      end

      chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
      chk("done_rdata",   bus.rdata, exp_rdata);
      chk("done_valid",   32'(bus.rdata_valid), 32'(exp_valid));
      chk("done_err",     32'(bus.io_err), 32'(exp_err));
      chk("done_sel",     32'(bus.dev_sel), 32'h0);
      rdata_hold = exp_rdata;

      bus.IORead  = 1'b0;
      bus.IOWrite = 1'b0;
      bus.dev_ack = '0;
      @(negedge clk);
      chk("post_valid", 32'(bus.rdata_valid), 32'h0);
      chk("post_err",   32'(bus.io_err), 32'h0);
      chk("post_rdata", bus.rdata, rdata_hold);
      chk("post_stall", 32'(bus.stall), 32'h0);
   endtask

   initial begin
      logic               r_rd, r_wr;
      logic [9:0]         r_a;
      logic [31:0]        r_bits;
      logic [NUM_DEV-1:0] r_stray;
      int                 r_dly;

      bus.IORead    = 1'b0;
      bus.IOWrite   = 1'b0;
      bus.addr_low  = '0;
      bus.wdata     = '0;
      bus.dev_rdata = '0;
      bus.dev_ack   = '0;
      for (int i = 0; i < NUM_DEV; i++) rv[i] = 32'h0;

      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("idle");

      // Switch read, immediate ack
      rv[0] = 32'h0000_00A5;
      run_access(1'b1, 1'b0, 10'h060, 32'h0, 0, '0);
      // LED write with three wait cycles
      run_access(1'b0, 1'b1, 10'h074, 32'h0000_1234, 3, '0);
      // Seg7 read never acked
      run_access(1'b1, 1'b0, 10'h080, 32'h0, 1000, '0);
      // Unmapped and boundary addresses
      run_access(1'b1, 1'b0, 10'h0A0, 32'h0, 0, '0);
      run_access(1'b1, 1'b0, 10'h05F, 32'h0, 0, '0);
      rv[3] = 32'hDEAD_BEEF;
      run_access(1'b1, 1'b0, 10'h09F, 32'h0, 1, '0);
      // Ack on the timeout cycle with a stray ack from slot 3
      rv[1] = 32'hCAFE_0001;
      run_access(1'b1, 1'b0, 10'h070, 32'h0, TIMEOUT - 1, 4'b1000);
      // Both strobes at once
      run_access(1'b1, 1'b1, 10'h064, 32'h5555_AAAA, 0, '0);
      // Write keeps the previous read data
      rv[2] = 32'h1111_2222;
      run_access(1'b1, 1'b0, 10'h088, 32'h0, 2, 4'b0001);
      run_access(1'b0, 1'b1, 10'h06C, 32'h7777_8888, 0, 4'b1111);

      // Reset while waiting for slot 1
      @(negedge clk);
      bus.IORead   = 1'b1;
      bus.addr_low = 10'h070;
      bus.wdata    = 32'h0BAD_F00D;
      repeat (3) @(negedge clk);
      chk("mid_sel", 32'(bus.dev_sel), 32'h2);
      rst = 1'b1;
      bus.IORead = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");
      rdata_hold = 32'h0;
      rst = 1'b0;
      rv[1] = 32'h0F0F_0F0F;
      run_access(1'b1, 1'b0, 10'h070, 32'h0, 0, '0);

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            r_rd = 1'b1;
            r_wr = 1'b1;
         end else begin
            r_rd = 1'($urandom_range(0, 1));
            r_wr = !r_rd;
         end
         r_bits = $urandom;
         if ($urandom_range(0, 3) == 0) r_a = r_bits[9:0];
         else r_a = 10'(BASE + $urandom_range(0, 16 * NUM_DEV - 1));
         r_dly = $urandom_range(0, TIMEOUT + 2);
         r_bits = $urandom;
         r_stray = r_bits[NUM_DEV-1:0];
         for (int i = 0; i < NUM_DEV; i++) rv[i] = $urandom;
         run_access(r_rd, r_wr, r_a, $urandom, r_dly, r_stray);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
